// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Frame-atomic round-robin arbiter sharing one uart_transmitter
//             between two byte-stream requesters. Port 0 carries
//             debug-peripheral responses. Port 1 carries CPU console output.
//             Once a requester has sent a byte, it keeps the link until it
//             sends the byte marked Last, so frames never interleave.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT_CYCLES  Number of idle LOCKED cycles after which the lock is
//                    released. Used only when UART_TX_ARB_TIMEOUT_EN is
//                    defined.
//  Build option
//    UART_TX_ARB_TIMEOUT_EN  When defined, a mid-frame lock whose owner stays
//                            idle is released after TIMEOUT_CYCLES cycles.
//                            When undefined, a lock is held indefinitely and
//                            o_Timeout is tied to 0.
//  Ports
//    i_Clock, i_Reset         Clock and asynchronous active-high reset.
//    i_ReqN_Valid/Byte/Last   Requester byte stream (N = 0, 1).
//    o_ReqN_Ready             Combinational. A byte moves when valid && ready.
//    o_Tx_DV, o_Tx_Byte       Registered handshake to the transmitter.
//    i_Tx_Done                One-cycle pulse when the transmitter has
//                             finished sending the byte.
//    o_Grant                  Registered one-hot link owner (00 = unowned).
//    o_Timeout                One-cycle pulse when a lock is released by
//                             the timeout.
// ============================================================================
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Req0_Valid,
    input  logic [7:0] i_Req0_Byte,
    input  logic       i_Req0_Last,
    output logic       o_Req0_Ready,
    input  logic       i_Req1_Valid,
    input  logic [7:0] i_Req1_Byte,
    input  logic       i_Req1_Last,
    output logic       o_Req1_Ready,
    output logic       o_Tx_DV,
    output logic [7:0] o_Tx_Byte,
    input  logic       i_Tx_Done,
    output logic [1:0] o_Grant,
    output logic       o_Timeout
);

    // A zero timeout would make the expiry compare wrap to all-ones.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_range
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t     r_State;
    logic       r_Tx_DV;
    logic [7:0] r_Tx_Byte;
    logic [1:0] r_Grant;
    logic       r_Last_Grant;   // index of the port that moved the most recent byte
    logic       r_Is_Last;      // byte in flight closes its frame

    logic       w_Sel0;
    logic       w_Sel1;
    logic       w_Xfer;
    logic       w_Expire;

    // Port selection. In IDLE a tie goes to the port that did not move the
    // previous byte. In LOCKED only the owner is offered the link, whether or
    // not it is currently valid. Readies depend only on state, grant and
    // valids, never on i_Tx_Done.
    always_comb begin
        w_Sel0 = 1'b0;
        w_Sel1 = 1'b0;
        case (r_State)
            S_IDLE: begin
                if (i_Req0_Valid && i_Req1_Valid) begin
                    w_Sel0 = r_Last_Grant;
                    w_Sel1 = ~r_Last_Grant;
                end else begin
                    w_Sel0 = i_Req0_Valid;
                    w_Sel1 = i_Req1_Valid;
                end
            end
            S_LOCKED: begin
                w_Sel0 = r_Grant[0];
                w_Sel1 = r_Grant[1];
            end
            default: begin
            end
        endcase
    end

    assign o_Req0_Ready = w_Sel0;
    assign o_Req1_Ready = w_Sel1;
    assign w_Xfer       = (w_Sel0 & i_Req0_Valid) | (w_Sel1 & i_Req1_Valid);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State      <= S_IDLE;
            r_Tx_DV      <= 1'b0;
            r_Tx_Byte    <= 8'h00;
            r_Grant      <= 2'b00;
            r_Last_Grant <= 1'b1;
            r_Is_Last    <= 1'b0;
        end else begin
            case (r_State)
                S_IDLE, S_LOCKED: begin
                    if (w_Xfer) begin
                        r_Tx_DV      <= 1'b1;
                        r_Tx_Byte    <= w_Sel1 ? i_Req1_Byte : i_Req0_Byte;
                        r_Is_Last    <= w_Sel1 ? i_Req1_Last : i_Req0_Last;
                        r_Grant      <= {w_Sel1, w_Sel0};
                        r_Last_Grant <= w_Sel1;
                        r_State      <= S_SEND;
                    end else if (w_Expire) begin
                        // r_Last_Grant is kept, so the other port wins the next tie.
                        r_Grant <= 2'b00;
                        r_State <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (i_Tx_Done) begin
                        r_Tx_DV   <= 1'b0;
                        r_Tx_Byte <= 8'h00;
                        if (r_Is_Last) begin
                            r_Grant <= 2'b00;
                            r_State <= S_IDLE;
                        end else begin
                            r_State <= S_LOCKED;
                        end
                    end
                end
                default: begin
                    r_State <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Tx_DV   = r_Tx_DV;
    assign o_Tx_Byte = r_Tx_Byte;
    assign o_Grant   = r_Grant;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [31:0] r_Timeout_Count;
    logic        r_Timeout;
    logic        w_Owner_Valid;

    assign w_Owner_Valid = (r_Grant[0] & i_Req0_Valid) | (r_Grant[1] & i_Req1_Valid);

    // The owner is always ready in LOCKED, so an idle owner can never coincide
    // with a transfer. A transfer in the expiry cycle therefore wins.
    assign w_Expire = (r_State == S_LOCKED) && !w_Owner_Valid &&
                      (r_Timeout_Count == (TIMEOUT_CYCLES - 32'd1));

    // Counts consecutive idle LOCKED cycles. The counter sits at zero
    // everywhere else, which covers the clear on transfer and on LOCKED entry.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Timeout_Count <= 32'd0;
            r_Timeout       <= 1'b0;
        end else begin
            r_Timeout <= w_Expire;
            if ((r_State == S_LOCKED) && !w_Owner_Valid && !w_Expire) begin
                r_Timeout_Count <= r_Timeout_Count + 32'd1;
            end else begin
                r_Timeout_Count <= 32'd0;
            end
        end
    end

    assign o_Timeout = r_Timeout;
`else
    assign w_Expire  = 1'b0;
    assign o_Timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Self-checking bench for uart_tx_arbiter. A transaction-level
//             model of link ownership is compared with the DUT on every
//             cycle. Directed scenarios pin the model with literal
//             expectations, and a randomized phase follows.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int unsigned TO = 16;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, l0, r0, v1, l1, r1;
    logic [7:0] b0, b1;
    logic       dv, done, tmo;
    logic [7:0] tbyte;
    logic [1:0] grant;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Req0_Valid (v0),
        .i_Req0_Byte  (b0),
        .i_Req0_Last  (l0),
        .o_Req0_Ready (r0),
        .i_Req1_Valid (v1),
        .i_Req1_Byte  (b1),
        .i_Req1_Last  (l1),
        .o_Req1_Ready (r1),
        .o_Tx_DV      (dv),
        .o_Tx_Byte    (tbyte),
        .i_Tx_Done    (done),
        .o_Grant      (grant),
        .o_Timeout    (tmo)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural model: who owns the link ----------------
    int         m_owner;      // -1 when nobody holds the link
    int         m_last;       // port that moved the latest byte
    int         m_idle;       // consecutive idle cycles of a locked owner
    bit         m_inflight;   // a byte is with the transmitter
    bit         m_final;      // the in-flight byte closes its frame
    bit         m_to;
    logic [7:0] m_byte;
    logic       prev_dv = 1'b0;
    logic [7:0] wire_q[$];    // bytes as they appear on the transmitter

    function automatic int pick();
        if (m_inflight) return -1;
        if (m_owner >= 0) return m_owner;
        if (v0 && v1) return 1 - m_last;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_idle = 0;
        m_inflight = 0; m_final = 0; m_to = 0; m_byte = 8'h00;
    endtask

    task automatic model_step();
        int  c;
        bit  vc;
        c  = pick();
        vc = (c == 0) ? v0 : ((c == 1) ? v1 : 1'b0);
        m_to = 0;
        if (m_inflight) begin
            if (done) begin
                m_inflight = 0;
                m_byte     = 8'h00;
                if (m_final) m_owner = -1;
                m_idle = 0;
            end
        end else if (c >= 0 && vc) begin
            m_inflight = 1;
            m_byte     = (c == 1) ? b1 : b0;
            m_final    = (c == 1) ? l1 : l0;
            m_owner    = c;
            m_last     = c;
            m_idle     = 0;
        end else if (m_owner >= 0 && TO_EN) begin
            m_idle++;
            if (m_idle == int'(TO)) begin
                m_owner = -1;
                m_to    = 1;
                m_idle  = 0;
            end
        end
    endtask

    always @(negedge clk) begin : compare
        logic [1:0] eg;
        int         c;
        if (rst) model_reset();
        c  = pick();
        eg = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        checks++;
        if (dv !== m_inflight || tbyte !== m_byte || grant !== eg || tmo !== m_to ||
            r0 !== (c == 0) || r1 !== (c == 1)) begin
            failures++;
            $display("FAIL model t=%0t dv=%b/%b byte=%h/%h grant=%b/%b tmo=%b/%b rdy0=%b/%b rdy1=%b/%b (got/required)",
                     $time, dv, m_inflight, tbyte, m_byte, grant, eg, tmo, m_to,
                     r0, (c == 0), r1, (c == 1));
        end
        if (dv && !prev_dv) wire_q.push_back(tbyte);
        prev_dv = dv;
        if (!rst) model_step();
    end

    // ---------------- stimulus helpers ----------------
    bit x0, x1, s_r1, prev_done;
    bit tx_auto, spur;
    int tx_delay, tx_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // One clock: sample transfers before the edge, then drive after it.
    // Also emulates the transmitter: Done follows DV after tx_delay cycles.
    task automatic tick();
        @(negedge clk);
        x0   = v0 && r0 && !rst;
        x1   = v1 && r1 && !rst;
        s_r1 = r1;
        @(posedge clk);
        #1;
        prev_done = done;
        if (tx_auto) begin
            if (done) begin
                done = 1'b0;
            end else if (dv) begin
                if (tx_wait >= tx_delay) begin
                    done    = 1'b1;
                    tx_wait = 0;
                end else begin
                    tx_wait++;
                end
            end else begin
                tx_wait = 0;
                done    = spur && ($urandom_range(0, 7) == 0);
            end
        end
    endtask

    task automatic do_reset();
        v0 = 0; v1 = 0; l0 = 0; l1 = 0; b0 = 8'h00; b1 = 8'h00;
        done = 0; tx_wait = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            tick();
            if (!dv && grant == 2'b00) ok = 1;
        end
        if (!ok) expired(name);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          base, n0, hi, viol, seen, seen_at, tocnt, rem0, rem1;
        bit          fell, frame_done, got;
        logic [7:0]  exp2 [4];
        logic [7:0]  exp3 [4];

        rst = 1; v0 = 0; v1 = 0; l0 = 0; l1 = 0; b0 = 0; b1 = 0; done = 0;
        tx_auto = 0; spur = 0; tx_delay = 1; tx_wait = 0;
        tick();
        tick();
        check("reset dv", dv, 0);
        check("reset byte", tbyte, 0);
        check("reset grant", grant, 0);
        check("reset timeout", tmo, 0);
        rst = 0;
        tick();

        // Single-byte frame, Done 10 cycles after DV.
        do_reset();
        tx_auto = 1; tx_delay = 10;
        v0 = 1; b0 = 8'hA5; l0 = 1;
        tick();
        check("t1 dv rise", dv, 1);
        check("t1 byte", tbyte, 8'hA5);
        check("t1 grant", grant, 2'b01);
        v0 = 0; b0 = 8'h00; l0 = 0;
        hi = 1; fell = 0;
        for (int k = 0; k < 40 && !fell; k++) begin
            tick();
            if (dv) hi++;
            else begin
                fell = 1;
                check("t1 done before fall", prev_done, 1);
                check("t1 grant after", grant, 2'b00);
                check("t1 byte after", tbyte, 8'h00);
            end
        end
        if (!fell) expired("t1 dv fall");
        check("t1 dv width", hi, 11);

        // Tie and alternation of single-byte frames.
        do_reset();
        tx_delay = 2;
        exp2 = '{8'h01, 8'h02, 8'h01, 8'h02};
        base = wire_q.size();
        v0 = 1; b0 = 8'h01; l0 = 1;
        v1 = 1; b1 = 8'h02; l1 = 1;
        for (int k = 0; k < 100 && wire_q.size() < base + 4; k++) tick();
        v0 = 0; v1 = 0;
        if (wire_q.size() >= base + 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("t2 wire[%0d]", i), wire_q[base + i], exp2[i]);
        end else expired("t2 four bytes");
        wait_idle("t2 idle");

        // Frame atomicity: 3-byte frame on port 0, port 1 waiting.
        do_reset();
        tx_delay = 3;
        exp3 = '{8'h10, 8'h11, 8'h12, 8'h55};
        base = wire_q.size();
        n0 = 0; viol = 0; frame_done = 0;
        v0 = 1; b0 = 8'h10; l0 = 0;
        v1 = 1; b1 = 8'h55; l1 = 1;
        for (int k = 0; k < 200 && wire_q.size() < base + 4; k++) begin
            tick();
            if (s_r1 && !frame_done) viol++;
            if (prev_done && n0 == 3) frame_done = 1;
            if (x0) begin
                n0++;
                if (n0 == 1) b0 = 8'h11;
                else if (n0 == 2) begin b0 = 8'h12; l0 = 1; end
                else begin v0 = 0; l0 = 0; end
            end
            if (x1) v1 = 0;
        end
        v0 = 0; v1 = 0;
        if (wire_q.size() >= base + 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("t3 wire[%0d]", i), wire_q[base + i], exp3[i]);
        end else expired("t3 four bytes");
        check("t3 ready1 early", viol, 0);
        wait_idle("t3 idle");

        // Reset while byte 2 of a frame is in SEND.
        do_reset();
        tx_delay = 4;
        n0 = 0; got = 0;
        v0 = 1; b0 = 8'h20; l0 = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            tick();
            if (x0) begin
                n0++;
                if (n0 == 1) b0 = 8'h21;
                else if (n0 == 2) begin b0 = 8'h22; l0 = 1; end
                else v0 = 0;
            end
            if (dv && tbyte == 8'h21) got = 1;
        end
        if (!got) expired("t4 byte2 in flight");
        rst = 1;
        #1;
        check("t4 reset dv", dv, 0);
        check("t4 reset byte", tbyte, 0);
        check("t4 reset grant", grant, 0);
        check("t4 reset timeout", tmo, 0);
        v0 = 0; l0 = 0;
        tick();
        rst = 0;
        v1 = 1; b1 = 8'h77; l1 = 1;
        tick();
        check("t4 req1 dv", dv, 1);
        check("t4 req1 byte", tbyte, 8'h77);
        check("t4 req1 grant", grant, 2'b10);
        v1 = 0;
        wait_idle("t4 idle");

        // Done pulses outside SEND are ignored.
        do_reset();
        tx_auto = 0;
        done = 1;
        tick();
        done = 0;
        check("t5 idle done dv", dv, 0);
        check("t5 idle done grant", grant, 2'b00);
        v0 = 1; b0 = 8'h30; l0 = 0;
        tick();
        check("t5 send byte", tbyte, 8'h30);
        v0 = 0;
        tick();
        done = 1;
        tick();
        done = 0;
        check("t5 locked dv", dv, 0);
        check("t5 locked grant", grant, 2'b01);
        v1 = 1; b1 = 8'h66; l1 = 1;
        done = 1;
        tick();
        done = 0;
        check("t5 locked done dv", dv, 0);
        check("t5 locked done grant", grant, 2'b01);
        check("t5 locked ready1", r1, 0);
        v0 = 1; b0 = 8'h31; l0 = 1;
        tick();
        check("t5 closing byte", tbyte, 8'h31);
        v0 = 0;
        tx_auto = 1; tx_delay = 1; tx_wait = 0;
        got = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            tick();
            if (dv && grant == 2'b10) begin
                got = 1;
                check("t5 req1 byte", tbyte, 8'h66);
                v1 = 0;
            end
        end
        if (!got) expired("t5 req1 served");
        wait_idle("t5 idle");

        // Idle owner mid-frame while port 1 waits.
        do_reset();
        tx_delay = 3;
        v0 = 1; b0 = 8'h40; l0 = 0;
        v1 = 1; b1 = 8'h41; l1 = 1;
        tick();
        check("t6 first byte", tbyte, 8'h40);
        v0 = 0;
        got = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            tick();
            if (done) got = 1;
        end
        if (!got) expired("t6 done");
        seen = 0; seen_at = 0; tocnt = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (tmo) tocnt++;
            if (!seen && dv) begin
                seen = 1;
                seen_at = k;
                check("t6 req1 byte", tbyte, 8'h41);
                v1 = 0;
            end
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        check("t6 timeout pulses", tocnt, 1);
        check("t6 req1 served", seen, 1);
        check("t6 req1 within 18", (seen_at >= 1 && seen_at <= 18), 1);
`else
        check("t6 no timeout", tocnt, 0);
        check("t6 req1 starved", seen, 0);
`endif
        v1 = 0;
        v0 = 1; b0 = 8'h42; l0 = 1;
        tick();
        v0 = 0;
        wait_idle("t6 idle");

        // Randomized traffic against the model.
        do_reset();
        spur = 1;
        rem0 = $urandom_range(1, 4);
        rem1 = $urandom_range(1, 4);
        for (int k = 0; k < 4000; k++) begin
            tx_delay = $urandom_range(0, 5);
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            l0 = (rem0 == 1);
            l1 = (rem1 == 1);
            if ((k % 400) >= 370) begin
                v0 = 0; v1 = 0;
            end else begin
                v0 = ($urandom_range(0, 99) < 70);
                v1 = ($urandom_range(0, 99) < 70);
            end
            tick();
            if (x0) begin
                rem0--;
                if (rem0 == 0) rem0 = $urandom_range(1, 4);
            end
            if (x1) begin
                rem1--;
                if (rem1 == 0) rem1 = $urandom_range(1, 4);
            end
        end
        v0 = 0; v1 = 0; spur = 0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-atomic, round-robin arbiter that shares the single debug-link `uart_transmitter` between two byte-stream requesters: port 0 carries debug-peripheral responses and port 1 carries CPU console output. It accepts one byte at a time, drives the transmitter's DV/byte/done handshake, and holds the grant on one requester until that requester marks the last byte of its frame. It sits between the requesters' output FIFOs and `uart_transmitter`, so frames are never interleaved on the wire.

## Interface
- `TIMEOUT_CYCLES`, default 100000: cycles a locked requester may stay idle mid-frame before the lock is released. Only used when `UART_TX_ARB_TIMEOUT_EN` is defined.
- `i_Clock`  in  1  system clock
- `i_Reset`  in  1  asynchronous, active-high reset
- `i_Req0_Valid`  in  1  port 0 has a byte
- `i_Req0_Byte`  in  8  port 0 byte
- `i_Req0_Last`  in  1  port 0 byte is the final byte of its frame
- `o_Req0_Ready`  out  1  combinational; a transfer occurs when valid && ready
- `i_Req1_Valid`, `i_Req1_Byte`, `i_Req1_Last`, `o_Req1_Ready`: same as port 0, for port 1
- `o_Tx_DV`  out  1  registered; to transmitter `i_Tx_DV`
- `o_Tx_Byte`  out  8  registered; to transmitter `i_Tx_Byte`
- `i_Tx_Done`  in  1  one-cycle pulse from the transmitter when the byte has been sent
- `o_Grant`  out  2  registered, one-hot owner of the link; 00 when unowned
- `o_Timeout`  out  1  one-cycle pulse when a lock is released by timeout

## Operation
- States are IDLE, SEND and LOCKED.
- **IDLE**
  - `o_Grant` = 00.
  - If exactly one valid is high, that port is selected.
  - If both are high, the port not in `r_Last_Grant` is selected. `r_Last_Grant` resets to 1, so port 0 wins the first tie.
  - `o_ReqN_Ready` = 1 only for the selected port.
- **On transfer**
  - Byte goes into `o_Tx_Byte`; `o_Tx_DV` <= 1.
  - `o_Grant` <= that port; `r_Last_Grant` <= that port.
  - `r_Is_Last` <= Last.
  - State <= SEND.
- **SEND**
  - `o_Tx_DV` and `o_Tx_Byte` are held stable; both readies are 0.
  - On `i_Tx_Done`: `o_Tx_DV` <= 0 and `o_Tx_Byte` <= 0.
  - If `r_Is_Last`: state <= IDLE, `o_Grant` <= 00. Otherwise state <= LOCKED.
- **LOCKED**
  - Ready is high only for the granted port; the other port is ignored even if valid.
  - A transfer behaves as in IDLE and goes to SEND, keeping the grant.
- Single-byte frames (Last on the first byte) return to IDLE after one SEND.
- Valid may deassert without a transfer at any time with no effect. Byte and Last are sampled only at the transfer cycle.
- `i_Tx_Done` outside SEND is ignored.

## Timing
- Reset (async, in any state):
  - state = IDLE
  - `o_Tx_DV` = 0, `o_Tx_Byte` = 0
  - `o_Grant` = 00, `o_Timeout` = 0
  - `r_Last_Grant` = 1, timeout counter = 0
  - Any in-flight frame is dropped. There is no partial-frame recovery after reset.
- Latency:
  - Transfer at cycle N gives `o_Tx_DV` = 1 at N+1.
  - `i_Tx_Done` at cycle M gives `o_Tx_DV` = 0 at M+1.
  - Ready may be high at M+1, so the next `o_Tx_DV` rise is at M+2 at the earliest.
- DV is guaranteed low for at least one cycle between bytes.
- Sustained throughput is one byte per (transmitter byte time + 2) cycles.
- Readies are combinational from state, grant and valids. They have no path from `i_Tx_Done`.

## Configuration
- **With `UART_TX_ARB_TIMEOUT_EN` defined:**
  - A 32-bit counter clears on every transfer and on every entry into LOCKED.
  - It increments each LOCKED cycle in which the granted valid is low.
  - When it reaches `TIMEOUT_CYCLES`-1:
    - next state = IDLE
    - `o_Grant` <= 00
    - `o_Timeout` pulses for one cycle
    - `r_Last_Grant` is unchanged, so the other port wins the next tie
  - A transfer in the same cycle as expiry wins: the transfer occurs and no timeout is raised.
- **Without the macro:**
  - LOCKED holds indefinitely.
  - `o_Timeout` is constant 0.
  - No counter is synthesized.

## Test plan
- **Single-byte frame:** Req0 byte 0xA5, Last=1; transmitter Done 10 cycles after DV.
  - `o_Tx_DV` rises 1 cycle after the transfer with `o_Tx_Byte` = 0xA5.
  - DV drops 1 cycle after Done; `o_Grant` returns to 00.
- **Tie and alternation:** both ports valid from reset, each sending 1-byte frames 0x01 (port 0) and 0x02 (port 1) continuously.
  - Wire order is 0x01, 0x02, 0x01, 0x02.
- **Frame atomicity:** Req0 sends a 3-byte frame 0x10, 0x11, 0x12 (Last on 0x12) while Req1 holds valid with 0x55 throughout.
  - Wire order is 0x10, 0x11, 0x12, 0x55.
  - `o_Req1_Ready` stays 0 until after the Done for 0x12.
- **Reset mid-SEND:** assert `i_Reset` while DV=1 during byte 2 of a frame.
  - All outputs go to reset values immediately.
  - After release, Req1 valid is granted from IDLE.
- **Timeout (macro on, `TIMEOUT_CYCLES`=16):** Req0 sends a non-last byte, then drops valid; Req1 is valid.
  - `o_Timeout` pulses once.
  - Req1's byte appears on `o_Tx_Byte` within 18 cycles of Done.
  - With the macro off, Req1 is never served.
- **Done outside SEND:** pulse `i_Tx_Done` while in IDLE and while in LOCKED.
  - No state, grant or DV change occurs.
